pc_register: RTL and testbench

PC_REGISTER -- requirements
Module: pc_register

---
 rtl/pc_register.sv | 100 ++++++++++
 tb/tb_pc_register.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_register.sv
// Program-counter byte pair (PCL/PCH) with optional 6502-style page-fixup cycle.
// Build macro: PC_PAGE_FIXUP_EN applies the PCH adjust in a separate FIXUP cycle.
//
// state | meaning
// IDLE  | normal operation; captures next-PC bytes on pcWrite_EN
// FIXUP | one-cycle PCH carry/borrow fixup, sequencer stalled (macro builds only)
module pc_register (
  input  logic       clock_IN,
  input  logic       resetN_IN,
  input  logic       pcWrite_EN,
  input  logic [7:0] pcLow_IN,
  input  logic       pcLowCarry_IN,
  input  logic       pcLowBorrow_IN,
  input  logic [7:0] pcHigh_IN,
  output logic [7:0] pcLow_OUT,
  output logic [7:0] pcHigh_OUT,
  output logic       fixup_OUT
);

  logic [7:0] pcl;
  logic [7:0] pch;
  logic [7:0] adj_ext;

  // Carry and borrow together cancel out; adjust is sign-extended to a byte.
  always_comb begin
    adj_ext = 8'h00;
    case ({pcLowCarry_IN, pcLowBorrow_IN})
      2'b10:   adj_ext = 8'h01;
      2'b01:   adj_ext = 8'hFF;
      default: adj_ext = 8'h00;
    endcase
  end

`ifdef PC_PAGE_FIXUP_EN
  typedef enum logic {IDLE, FIXUP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] adj_q;
  logic [7:0] adj_nxt;
  logic [7:0] pcl_nxt;
  logic [7:0] pch_nxt;

  always_comb begin
    state_nxt = state;
    adj_nxt   = adj_q;
    pcl_nxt   = pcl;
    pch_nxt   = pch;
    case (state)
      IDLE: begin
        if (pcWrite_EN) begin
          pcl_nxt = pcLow_IN;
          pch_nxt = pcHigh_IN;
          adj_nxt = adj_ext;
          if (adj_ext != 8'h00) state_nxt = FIXUP;
        end
      end
      FIXUP: begin
        // All inputs are ignored here; only the captured adjust matters.
        pch_nxt   = pch + adj_q;
        adj_nxt   = 8'h00;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_IN or negedge resetN_IN) begin
    if (!resetN_IN) begin
      state <= IDLE;
      adj_q <= 8'h00;
      pcl   <= 8'h00;
      pch   <= 8'h00;
    end else begin
      state <= state_nxt;
      adj_q <= adj_nxt;
      pcl   <= pcl_nxt;
      pch   <= pch_nxt;
    end
  end

  assign fixup_OUT = (state == FIXUP);
`else
  always_ff @(posedge clock_IN or negedge resetN_IN) begin
    if (!resetN_IN) begin
      pcl <= 8'h00;
      pch <= 8'h00;
    end else if (pcWrite_EN) begin
      pcl <= pcLow_IN;
      pch <= pcHigh_IN + adj_ext;
    end
  end

  assign fixup_OUT = 1'b0;
`endif

  assign pcLow_OUT  = pcl;
  assign pcHigh_OUT = pch;

endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register; expectations follow PC_PAGE_FIXUP_EN when defined.
module tb_pc_register;

  logic       clock_IN = 1'b0;
  logic       resetN_IN;
  logic       pcWrite_EN;
  logic [7:0] pcLow_IN;
  logic       pcLowCarry_IN;
  logic       pcLowBorrow_IN;
  logic [7:0] pcHigh_IN;
  logic [7:0] pcLow_OUT;
  logic [7:0] pcHigh_OUT;
  logic       fixup_OUT;

  int vectors = 0;
  int miscompares = 0;

  pc_register dut (
    .clock_IN       (clock_IN),
    .resetN_IN      (resetN_IN),
    .pcWrite_EN     (pcWrite_EN),
    .pcLow_IN       (pcLow_IN),
    .pcLowCarry_IN  (pcLowCarry_IN),
    .pcLowBorrow_IN (pcLowBorrow_IN),
    .pcHigh_IN      (pcHigh_IN),
    .pcLow_OUT      (pcLow_OUT),
    .pcHigh_OUT     (pcHigh_OUT),
    .fixup_OUT      (fixup_OUT)
  );

  always #5 clock_IN = ~clock_IN;

  // Drive one write on the next edge, then drop the enable; returns #1 after the edge.
  task automatic write_cycle(input logic [7:0] lo, input logic [7:0] hi,
                             input logic c, input logic b, input logic en);
    @(negedge clock_IN);
    pcWrite_EN = en; pcLow_IN = lo; pcHigh_IN = hi;
    pcLowCarry_IN = c; pcLowBorrow_IN = b;
    @(posedge clock_IN);
    #1;
    pcWrite_EN = 1'b0; pcLowCarry_IN = 1'b0; pcLowBorrow_IN = 1'b0;
  endtask

  task automatic test_reset();
    pcWrite_EN = 1'b0; pcLow_IN = 8'hAA; pcHigh_IN = 8'hBB;
    pcLowCarry_IN = 1'b1; pcLowBorrow_IN = 1'b0;
    resetN_IN = 1'b0;
    #12;
    vectors++;
    if (pcLow_OUT !== 8'h00) begin miscompares++; $display("FAIL reset_pcl got %h want 00", pcLow_OUT); end
    vectors++;
    if (pcHigh_OUT !== 8'h00) begin miscompares++; $display("FAIL reset_pch got %h want 00", pcHigh_OUT); end
    vectors++;
    if (fixup_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_fixup got %b want 0", fixup_OUT); end
    // Release with write already pending: first edge after release captures.
    @(negedge clock_IN);
    pcLowCarry_IN = 1'b0;
    pcWrite_EN = 1'b1; pcLow_IN = 8'h77; pcHigh_IN = 8'h21;
    resetN_IN = 1'b1;
    @(posedge clock_IN);
    #1;
    pcWrite_EN = 1'b0;
    vectors++;
    if (pcLow_OUT !== 8'h77) begin miscompares++; $display("FAIL first_capture_pcl got %h want 77", pcLow_OUT); end
    vectors++;
    if (pcHigh_OUT !== 8'h21) begin miscompares++; $display("FAIL first_capture_pch got %h want 21", pcHigh_OUT); end
  endtask

  task automatic test_hold();
    write_cycle(8'h99, 8'h88, 1'b1, 1'b0, 1'b0);
    write_cycle(8'h55, 8'h44, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (pcLow_OUT !== 8'h77) begin miscompares++; $display("FAIL hold_pcl got %h want 77", pcLow_OUT); end
    vectors++;
    if (pcHigh_OUT !== 8'h21) begin miscompares++; $display("FAIL hold_pch got %h want 21", pcHigh_OUT); end
    vectors++;
    if (fixup_OUT !== 1'b0) begin miscompares++; $display("FAIL hold_fixup got %b want 0", fixup_OUT); end
  endtask

  task automatic test_plain_write();
    write_cycle(8'h56, 8'h34, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (pcLow_OUT !== 8'h56) begin miscompares++; $display("FAIL plain_pcl got %h want 56", pcLow_OUT); end
    vectors++;
    if (pcHigh_OUT !== 8'h34) begin miscompares++; $display("FAIL plain_pch got %h want 34", pcHigh_OUT); end
    vectors++;
    if (fixup_OUT !== 1'b0) begin miscompares++; $display("FAIL plain_fixup got %b want 0", fixup_OUT); end
  endtask

  // Carry, borrow and wrap cases: {pcl, pch_in, carry, borrow, pch_final}.
  task automatic test_adjust();
    logic [7:0] lo_v [4] = '{8'h00, 8'hF0, 8'h01, 8'h3C};
    logic [7:0] hi_v [4] = '{8'h12, 8'h00, 8'hFF, 8'h40};
    logic       c_v  [4] = '{1'b1,  1'b0,  1'b1,  1'b1};
    logic       b_v  [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] ex_v [4] = '{8'h13, 8'hFF, 8'h00, 8'h40};
    for (int i = 0; i < 4; i++) begin
      write_cycle(lo_v[i], hi_v[i], c_v[i], b_v[i], 1'b1);
`ifdef PC_PAGE_FIXUP_EN
      if (c_v[i] != b_v[i]) begin
        vectors++;
        if (pcHigh_OUT !== hi_v[i]) begin miscompares++; $display("FAIL adj%0d_pch_c1 got %h want %h", i, pcHigh_OUT, hi_v[i]); end
        vectors++;
        if (fixup_OUT !== 1'b1) begin miscompares++; $display("FAIL adj%0d_fixup_c1 got %b want 1", i, fixup_OUT); end
        // A write pulse during the fixup cycle must be ignored.
        write_cycle(8'hEE, 8'hDD, 1'b0, 1'b1, 1'b1);
      end
`endif
      vectors++;
      if (pcHigh_OUT !== ex_v[i]) begin miscompares++; $display("FAIL adj%0d_pch got %h want %h", i, pcHigh_OUT, ex_v[i]); end
      vectors++;
      if (pcLow_OUT !== lo_v[i]) begin miscompares++; $display("FAIL adj%0d_pcl got %h want %h", i, pcLow_OUT, lo_v[i]); end
      vectors++;
      if (fixup_OUT !== 1'b0) begin miscompares++; $display("FAIL adj%0d_fixup got %b want 0", i, fixup_OUT); end
    end
    // Idle one more cycle: nothing may change afterwards.
    write_cycle(8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (pcHigh_OUT !== 8'h40) begin miscompares++; $display("FAIL adj_settle_pch got %h want 40", pcHigh_OUT); end
  endtask

  task automatic test_reset_mid_fixup();
    write_cycle(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1);
`ifdef PC_PAGE_FIXUP_EN
    vectors++;
    if (fixup_OUT !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_fixup got %b want 1", fixup_OUT); end
`else
    vectors++;
    if (pcHigh_OUT !== 8'h80) begin miscompares++; $display("FAIL midrst_pre_pch got %h want 80", pcHigh_OUT); end
`endif
    #2;
    resetN_IN = 1'b0;
    #1;
    vectors++;
    if (pcLow_OUT !== 8'h00) begin miscompares++; $display("FAIL midrst_pcl got %h want 00", pcLow_OUT); end
    vectors++;
    if (pcHigh_OUT !== 8'h00) begin miscompares++; $display("FAIL midrst_pch got %h want 00", pcHigh_OUT); end
    vectors++;
    if (fixup_OUT !== 1'b0) begin miscompares++; $display("FAIL midrst_fixup got %b want 0", fixup_OUT); end
    @(negedge clock_IN);
    resetN_IN = 1'b1;
    write_cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    write_cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (pcHigh_OUT !== 8'h00) begin miscompares++; $display("FAIL midrst_no_deferred got %h want 00", pcHigh_OUT); end
    vectors++;
    if (fixup_OUT !== 1'b0) begin miscompares++; $display("FAIL midrst_after_fixup got %b want 0", fixup_OUT); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_plain_write();
    test_adjust();
    test_reset_mid_fixup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
